// File: rtl/cle_stats.sv
// rtl/cle_stats.sv - post-labeling scan building a per-label area/bbox table
// Optional bounding-box storage enabled by defining CLE_STATS_BBOX_EN.
module cle_stats #(
  parameter int MAX_OBJ = 8,
  parameter int IDX_W   = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [7:0]       sram_q_i,
  output logic [9:0]       sram_a_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [IDX_W:0]   obj_cnt_o,
  output logic             overflow_o,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_valid_o,
  output logic [7:0]       rd_label_o,
  output logic [10:0]      rd_area_o,
  output logic [4:0]       rd_rmin_o,
  output logic [4:0]       rd_rmax_o,
  output logic [4:0]       rd_cmin_o,
  output logic [4:0]       rd_cmax_o
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [9:0]      addr_q, addr_d;
  logic            p_vld_q, p_vld_d;
  logic [IDX_W:0]  cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;
  logic [7:0]      label_q [MAX_OBJ];
  logic [7:0]      label_d [MAX_OBJ];
  logic [10:0]     area_q  [MAX_OBJ];
  logic [10:0]     area_d  [MAX_OBJ];
  logic            hit;
  logic [IDX_W-1:0] hit_idx, new_idx;
`ifdef CLE_STATS_BBOX_EN
  logic [9:0]      p_addr_q, p_addr_d;
  logic [4:0]      rmin_q [MAX_OBJ], rmin_d [MAX_OBJ];
  logic [4:0]      rmax_q [MAX_OBJ], rmax_d [MAX_OBJ];
  logic [4:0]      cmin_q [MAX_OBJ], cmin_d [MAX_OBJ];
  logic [4:0]      cmax_q [MAX_OBJ], cmax_d [MAX_OBJ];
  logic [4:0]      pix_r, pix_c;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    p_vld_d = 1'b0;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    done_d  = done_q;
    label_d = label_q;
    area_d  = area_q;
    hit     = 1'b0;
    hit_idx = '0;
    new_idx = cnt_q[IDX_W-1:0];
`ifdef CLE_STATS_BBOX_EN
    p_addr_d = addr_q;
    rmin_d   = rmin_q;
    rmax_d   = rmax_q;
    cmin_d   = cmin_q;
    cmax_d   = cmax_q;
    pix_r    = p_addr_q[9:5];
    pix_c    = p_addr_q[4:0];
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_SCAN;
          addr_d  = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          done_d  = 1'b0;
          for (int i = 0; i < MAX_OBJ; i++) begin
            label_d[i] = '0;
            area_d[i]  = '0;
`ifdef CLE_STATS_BBOX_EN
            rmin_d[i] = '0;
            rmax_d[i] = '0;
            cmin_d[i] = '0;
            cmax_d[i] = '0;
`endif
          end
        end
      end
      S_SCAN: begin
        p_vld_d = 1'b1;
        if (addr_q == 10'd1023) state_d = S_DRAIN;
        else                    addr_d  = addr_q + 10'd1;
      end
      S_DRAIN: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    for (int i = 0; i < MAX_OBJ; i++) begin
      if ((IDX_W+1)'(i) < cnt_q && label_q[i] == sram_q_i) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end

    // p_vld_q is only set in SCAN/DRAIN, so this never collides with the start-time clear
    if (p_vld_q && sram_q_i != 8'd0) begin
      if (hit) begin
        area_d[hit_idx] = area_q[hit_idx] + 11'd1;
`ifdef CLE_STATS_BBOX_EN
        rmin_d[hit_idx] = (pix_r < rmin_q[hit_idx]) ? pix_r : rmin_q[hit_idx];
        rmax_d[hit_idx] = (pix_r > rmax_q[hit_idx]) ? pix_r : rmax_q[hit_idx];
        cmin_d[hit_idx] = (pix_c < cmin_q[hit_idx]) ? pix_c : cmin_q[hit_idx];
        cmax_d[hit_idx] = (pix_c > cmax_q[hit_idx]) ? pix_c : cmax_q[hit_idx];
`endif
      end else if (cnt_q < (IDX_W+1)'(MAX_OBJ)) begin
        label_d[new_idx] = sram_q_i;
        area_d[new_idx]  = 11'd1;
`ifdef CLE_STATS_BBOX_EN
        rmin_d[new_idx] = pix_r;
        rmax_d[new_idx] = pix_r;
        cmin_d[new_idx] = pix_c;
        cmax_d[new_idx] = pix_c;
`endif
        cnt_d = cnt_q + 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      p_vld_q <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < MAX_OBJ; i++) begin
        label_q[i] <= '0;
        area_q[i]  <= '0;
`ifdef CLE_STATS_BBOX_EN
        rmin_q[i] <= '0;
        rmax_q[i] <= '0;
        cmin_q[i] <= '0;
        cmax_q[i] <= '0;
`endif
      end
`ifdef CLE_STATS_BBOX_EN
      p_addr_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      p_vld_q <= p_vld_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      for (int i = 0; i < MAX_OBJ; i++) begin
        label_q[i] <= label_d[i];
        area_q[i]  <= area_d[i];
`ifdef CLE_STATS_BBOX_EN
        rmin_q[i] <= rmin_d[i];
        rmax_q[i] <= rmax_d[i];
        cmin_q[i] <= cmin_d[i];
        cmax_q[i] <= cmax_d[i];
`endif
      end
`ifdef CLE_STATS_BBOX_EN
      p_addr_q <= p_addr_d;
`endif
    end
  end

  assign sram_a_o   = addr_q;
  assign busy_o     = (state_q == S_SCAN) || (state_q == S_DRAIN);
  assign done_o     = done_q;
  assign obj_cnt_o  = cnt_q;
  assign overflow_o = ovf_q;
  assign rd_valid_o = ({1'b0, rd_idx_i} < cnt_q);
  assign rd_label_o = rd_valid_o ? label_q[rd_idx_i] : 8'd0;
  assign rd_area_o  = rd_valid_o ? area_q[rd_idx_i]  : 11'd0;
`ifdef CLE_STATS_BBOX_EN
  assign rd_rmin_o  = rd_valid_o ? rmin_q[rd_idx_i] : 5'd0;
  assign rd_rmax_o  = rd_valid_o ? rmax_q[rd_idx_i] : 5'd0;
  assign rd_cmin_o  = rd_valid_o ? cmin_q[rd_idx_i] : 5'd0;
  assign rd_cmax_o  = rd_valid_o ? cmax_q[rd_idx_i] : 5'd0;
`else
  assign rd_rmin_o  = 5'd0;
  assign rd_rmax_o  = 5'd0;
  assign rd_cmin_o  = 5'd0;
  assign rd_cmax_o  = 5'd0;
`endif

endmodule

// File: tb/tb_cle_stats.sv
// tb/tb_cle_stats.sv - randomized and directed self-checking bench for cle_stats
module tb_cle_stats;
  localparam int MAX_OBJ = 8;
  localparam int IDX_W   = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [7:0]       sram_q = '0;
  logic [9:0]       sram_a;
  logic             busy, done, overflow;
  logic [IDX_W:0]   obj_cnt;
  logic [IDX_W-1:0] rd_idx = '0;
  logic             rd_valid;
  logic [7:0]       rd_label;
  logic [10:0]      rd_area;
  logic [4:0]       rd_rmin, rd_rmax, rd_cmin, rd_cmax;

  cle_stats #(.MAX_OBJ(MAX_OBJ), .IDX_W(IDX_W)) dut (
    .clk_i(clk), .reset_i(rst), .start_i(start), .sram_q_i(sram_q), .sram_a_o(sram_a),
    .busy_o(busy), .done_o(done), .obj_cnt_o(obj_cnt), .overflow_o(overflow),
    .rd_idx_i(rd_idx), .rd_valid_o(rd_valid), .rd_label_o(rd_label), .rd_area_o(rd_area),
    .rd_rmin_o(rd_rmin), .rd_rmax_o(rd_rmax), .rd_cmin_o(rd_cmin), .rd_cmax_o(rd_cmax)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [1024];
  always @(posedge clk) sram_q <= mem[sram_a];

  int errors = 0;
  int checks = 0;
  bit model_ok = 0;

  int exp_cnt, exp_ovf;
  int exp_label [MAX_OBJ];
  int exp_area  [MAX_OBJ];
  int exp_rmin  [MAX_OBJ];
  int exp_rmax  [MAX_OBJ];
  int exp_cmin  [MAX_OBJ];
  int exp_cmax  [MAX_OBJ];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int bb(input int v);
`ifdef CLE_STATS_BBOX_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic compute_model();
    exp_cnt = 0;
    exp_ovf = 0;
    for (int i = 0; i < MAX_OBJ; i++) begin
      exp_label[i] = 0; exp_area[i] = 0;
      exp_rmin[i] = 0; exp_rmax[i] = 0; exp_cmin[i] = 0; exp_cmax[i] = 0;
    end
    for (int a = 0; a < 1024; a++) begin
      int lab, r, c, f;
      lab = mem[a];
      r = a / 32;
      c = a % 32;
      f = -1;
      if (lab == 0) continue;
      for (int i = 0; i < exp_cnt; i++) if (exp_label[i] == lab) f = i;
      if (f >= 0) begin
        exp_area[f]++;
        if (r < exp_rmin[f]) exp_rmin[f] = r;
        if (r > exp_rmax[f]) exp_rmax[f] = r;
        if (c < exp_cmin[f]) exp_cmin[f] = c;
        if (c > exp_cmax[f]) exp_cmax[f] = c;
      end else if (exp_cnt < MAX_OBJ) begin
        exp_label[exp_cnt] = lab; exp_area[exp_cnt] = 1;
        exp_rmin[exp_cnt] = r; exp_rmax[exp_cnt] = r;
        exp_cmin[exp_cnt] = c; exp_cmax[exp_cnt] = c;
        exp_cnt++;
      end else begin
        exp_ovf = 1;
      end
    end
  endtask

  // Whenever the table is final, every output must match the model for the selected index.
  always @(negedge clk) begin
    if (model_ok && done && !rst) begin
      int k;
      k = rd_idx;
      chk("obj_cnt", obj_cnt, exp_cnt);
      chk("overflow", overflow, exp_ovf);
      if (k < exp_cnt) begin
        chk("rd_valid", rd_valid, 1);
        chk("rd_label", rd_label, exp_label[k]);
        chk("rd_area", rd_area, exp_area[k]);
        chk("rd_rmin", rd_rmin, bb(exp_rmin[k]));
        chk("rd_rmax", rd_rmax, bb(exp_rmax[k]));
        chk("rd_cmin", rd_cmin, bb(exp_cmin[k]));
        chk("rd_cmax", rd_cmax, bb(exp_cmax[k]));
      end else begin
        chk("rd_valid_off", rd_valid, 0);
        chk("rd_off_zero", {rd_label, rd_area, rd_rmin, rd_rmax, rd_cmin, rd_cmax}, 0);
      end
    end
  end

  task automatic clear_mem();
    model_ok = 0;
    for (int a = 0; a < 1024; a++) mem[a] = 8'd0;
  endtask

  task automatic sweep();
    for (int i = 0; i < MAX_OBJ; i++) begin
      rd_idx = IDX_W'(i);
      @(posedge clk); #1;
    end
    repeat (16) begin
      rd_idx = IDX_W'($urandom_range(0, MAX_OBJ-1));
      @(posedge clk); #1;
    end
  endtask

  task automatic run_scan(input int restart_at, input int reset_at);
    int n;
    model_ok = 0;
    compute_model();
    @(negedge clk);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("busy_rise", busy, 1);
    chk("done_drop", done, 0);
    chk("addr_first", sram_a, 0);
    n = 0;
    while (!done && n < 1100) begin
      if (n == restart_at) start = 1;
      if (n == reset_at) rst = 1;
      @(posedge clk); #1;
      n++;
      start = 0;
      if (n - 1 == reset_at) begin
        rst = 0;
        chk("reset_busy", busy, 0);
        chk("reset_cnt", obj_cnt, 0);
        chk("reset_done", done, 0);
        return;
      end
    end
    chk("done_latency", n, 1025);
    chk("busy_end", busy, 0);
    chk("addr_hold", sram_a, 1023);
    model_ok = 1;
    sweep();
  endtask

  task automatic read_entry(input int i);
    rd_idx = IDX_W'(i);
    #1;
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = 8'd0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_addr", sram_a, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", obj_cnt, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_valid", rd_valid, 0);

    clear_mem();
    run_scan(-1, -1);
    chk("zero_model_cnt", exp_cnt, 0);

    clear_mem();
    mem[33] = 8'h05;
    run_scan(-1, -1);
    chk("t2_model_label", exp_label[0], 5);
    chk("t2_model_rmin", exp_rmin[0], 1);
    read_entry(0);
    chk("t2_cnt", obj_cnt, 1);
    chk("t2_label", rd_label, 5);
    chk("t2_area", rd_area, 1);
    chk("t2_cmax", rd_cmax, bb(1));

    clear_mem();
    for (int r = 2; r <= 4; r++) for (int c = 10; c <= 12; c++) mem[r*32+c] = 8'h07;
    for (int a = 1000; a <= 1003; a++) mem[a] = 8'h03;
    run_scan(-1, -1);
    chk("t3_model_area", exp_area[0], 9);
    chk("t3_model_cmin1", exp_cmin[1], 8);
    read_entry(1);
    chk("t3_label1", rd_label, 3);
    chk("t3_area1", rd_area, 4);
    chk("t3_rmin1", rd_rmin, bb(31));
    chk("t3_cmax1", rd_cmax, bb(11));

    clear_mem();
    for (int a = 0; a < 9; a++) mem[a] = 8'(a + 1);
    run_scan(-1, -1);
    chk("t4_model_ovf", exp_ovf, 1);
    read_entry(7);
    chk("t4_cnt", obj_cnt, 8);
    chk("t4_ovf", overflow, 1);
    chk("t4_label7", rd_label, 8);

    clear_mem();
    for (int a = 0; a < 1024; a++) mem[a] = 8'h42;
    run_scan(-1, -1);
    read_entry(0);
    chk("full_area", rd_area, 1024);

    clear_mem();
    for (int a = 0; a < 1024; a++)
      if ($urandom_range(0, 9) < 3) mem[a] = 8'($urandom_range(1, 5));
    run_scan(-1, 500);
    run_scan(-1, -1);
    run_scan(300, -1);
    run_scan(-1, -1);

    repeat (4) begin
      clear_mem();
      for (int a = 0; a < 1024; a++)
        if ($urandom_range(0, 99) < 15) mem[a] = 8'($urandom_range(1, $urandom_range(3, 255)));
      run_scan(-1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cle_stats.md
# cle_stats

Post-labeling statistics stage that sits downstream of the component labeling engine. After labeling asserts `finish`, this block scans the 1024x8 label SRAM (a 32x32 label map, address = row*32 + col) in address order. It builds a table of up to `MAX_OBJ` distinct nonzero labels, with area and bounding box per label, which the host reads back through an indexed port. The block only reads the SRAM; the SRAM mux and `sram_wen` (held high while this block owns the SRAM) belong to the top level.

## Interface
- `MAX_OBJ`, 8: number of table entries (distinct labels tracked).
- `IDX_W`, 3: width of `rd_idx`; must equal clog2(`MAX_OBJ`).

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `start`  in  1  one-cycle request to begin a scan (driven from CLE `finish` rising edge).
- `sram_q`  in  8  SRAM read data, valid the cycle after its address is presented.
- `sram_a`  out  10  SRAM read address.
- `busy`  out  1  high while scanning.
- `done`  out  1  level; high from scan completion until the next accepted `start` or `reset`.
- `obj_cnt`  out  IDX_W+1  number of valid table entries.
- `overflow`  out  1  a label was seen with the table already full.
- `rd_idx`  in  IDX_W  table entry select.
- `rd_valid`  out  1  combinational; selected entry is valid.
- `rd_label`  out  8  combinational; label value of the entry.
- `rd_area`  out  11  combinational; pixel count (0..1024).
- `rd_rmin`, `rd_rmax`, `rd_cmin`, `rd_cmax`  out  5 each  combinational; bounding box of the entry.

## Operation
- States are IDLE, SCAN, DRAIN and DONE.
- IDLE: `start` = 1 clears the table, `obj_cnt`, `overflow` and `done`, sets `addr` = 0, and moves to SCAN.
- SCAN: `sram_a` = `addr`, and `addr` increments each cycle. After the cycle that presents 1023, go to DRAIN.
- DRAIN: lasts one cycle and processes the final pixel, then goes to DONE.
- DONE: `start` behaves as in IDLE (full rescan).
- Pixel pipeline: a registered `p_addr` and `p_vld` follow `sram_a` by one cycle. When `p_vld` = 1, `sram_q` is the label at `p_addr`, with row = `p_addr[9:5]` and col = `p_addr[4:0]`.
- Per-pixel update, with label L = `sram_q`:
  - L = 0: background, no action.
  - L matches a valid entry (parallel compare): area += 1; rmin = min, rmax = max, cmin = min, cmax = max against the pixel position.
  - No match and `obj_cnt` < `MAX_OBJ`: allocate entry `obj_cnt` with label L, area 1, bbox = the pixel; `obj_cnt` += 1.
  - No match and table full: set `overflow` (sticky for the scan) and drop the pixel.
- Entry order is first-appearance order in the raster scan.
- The table updates at the clock edge. The next pixel's lookup sees the updated table, so back-to-back pixels of a new label hit the entry just allocated.
- `start` while `busy` is ignored.
- `reset` at any time (including mid-scan) returns to IDLE with the table cleared.
- `rd_*` may be read at any time. It reflects live table contents and is only meaningful when `done` = 1. For `rd_idx` ≥ `obj_cnt`, `rd_valid` = 0 and all other `rd_*` = 0.

## Timing
- Reset values: `sram_a` = 0, `busy` = 0, `done` = 0, `obj_cnt` = 0, `overflow` = 0, all entries invalid and zero.
- Edge E0 samples `start`. `busy` rises after E0, and `sram_a` = 0 during cycle E0..E1.
- `sram_a` = k during cycle Ek..Ek+1, for k = 0..1023.
- Pixel k is accumulated at edge Ek+2. The last pixel is accumulated at E1025.
- After E1025: `busy` = 0 and `done` = 1, i.e. `done` is visible 1025 cycles after the `start` edge.
- `sram_a` holds 1023 after the scan until the next `start`.
- Area is 11 bits, so a full 1024-pixel object is representable and never wraps.

## Configuration
- `CLE_STATS_BBOX_EN` defined: bounding-box registers and compare logic are present, as described above.
- Not defined: no bbox storage. `rd_rmin`, `rd_rmax`, `rd_cmin` and `rd_cmax` are tied to 0. Area, label, count and overflow are unchanged.

## Test plan
- All-zero SRAM, `start` -> `done` rises 1025 cycles after the `start` edge; `obj_cnt` = 0, `overflow` = 0, `rd_valid` = 0 for all indices.
- Single pixel 0x05 at address 33 -> `obj_cnt` = 1; entry 0: label 05, area 1, r 1..1, c 1..1. Without the macro, bbox reads 0.
- Label 0x07 filling rows 2..4 × cols 10..12, and label 0x03 at addresses 1000..1003 -> entry 0 = 07, area 9, r 2..4, c 10..12; entry 1 = 03, area 4, r 31..31, c 8..11.
- Nine distinct labels 1..9 at addresses 0..8 with `MAX_OBJ` = 8 -> `obj_cnt` = 8, `overflow` = 1, labels 1..8 retained, label 9 absent.
- `reset` asserted at cycle 500 of a scan -> next cycle `busy` = 0, `obj_cnt` = 0. A following `start` completes a normal scan with correct results.
- `start` pulsed again at cycle 300 of a scan -> ignored, and `done` timing is unchanged. `start` in DONE -> `done` drops and the table is rebuilt identically.
